// File: rtl/alu_op_sequencer.sv
// Command-side master for a 32-bit combinational ALU: accepts one request at a time,
// sequences one or two ALU passes and returns the result over a valid/ready handshake.
module alu_op_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_f,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_zero,
    output logic             res_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] OP_AND     = 4'd0;
    localparam logic [3:0] OP_OR      = 4'd1;
    localparam logic [3:0] OP_ADD     = 4'd2;
    localparam logic [3:0] OP_SUB     = 4'd3;
    localparam logic [3:0] OP_SLT     = 4'd4;
    localparam logic [3:0] OP_ANDN    = 4'd5;
    localparam logic [3:0] OP_ORN     = 4'd6;
    localparam logic [3:0] OP_EQ      = 4'd7;
    localparam logic [3:0] OP_MIN     = 4'd8;
    localparam logic [3:0] OP_MAX     = 4'd9;
    localparam logic [3:0] OP_ABSDIFF = 4'd10;

    localparam logic [2:0] F_AND  = 3'b000;
    localparam logic [2:0] F_OR   = 3'b001;
    localparam logic [2:0] F_ADD  = 3'b010;
    localparam logic [2:0] F_ANDN = 3'b100;
    localparam logic [2:0] F_ORN  = 3'b101;
    localparam logic [2:0] F_SUB  = 3'b110;
    localparam logic [2:0] F_SLT  = 3'b111;

    state_t           state, state_n;
    logic [3:0]       op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic             lt_q, lt_n;
    logic [WIDTH-1:0] alu_a_n, alu_b_n;
    logic [2:0]       alu_f_n;
    logic [WIDTH-1:0] res_data_n;
    logic             res_zero_n;
    logic             res_err_n;
    logic             res_load;

    // First-pass ALU function; composite ops all start with a compare or subtract.
    function automatic logic [2:0] first_func(input logic [3:0] op);
        case (op)
            OP_AND:     first_func = F_AND;
            OP_OR:      first_func = F_OR;
            OP_ADD:     first_func = F_ADD;
            OP_SUB:     first_func = F_SUB;
            OP_SLT:     first_func = F_SLT;
            OP_ANDN:    first_func = F_ANDN;
            OP_ORN:     first_func = F_ORN;
            OP_EQ:      first_func = F_SUB;
            default:    first_func = F_SLT;
        endcase
    endfunction

    assign cmd_ready = (state == IDLE);
    assign res_valid = (state == DONE);

    always_comb begin
        state_n    = state;
        op_n       = op_q;
        a_n        = a_q;
        b_n        = b_q;
        lt_n       = lt_q;
        alu_a_n    = alu_a;
        alu_b_n    = alu_b;
        alu_f_n    = F_AND;
        res_data_n = res_data;
        res_err_n  = res_err;
        res_load   = 1'b0;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    op_n = cmd_op;
                    a_n  = cmd_a;
                    b_n  = cmd_b;
                    if (cmd_op <= OP_ABSDIFF) begin
                        alu_a_n   = cmd_a;
                        alu_b_n   = cmd_b;
                        alu_f_n   = first_func(cmd_op);
                        res_err_n = 1'b0;
                        state_n   = EXEC1;
                    end else begin
                        res_data_n = '0;
                        res_err_n  = 1'b1;
                        res_load   = 1'b1;
                        state_n    = DONE;
                    end
                end
            end

            EXEC1: begin
                state_n = DONE;
                case (op_q)
                    OP_EQ: begin
                        res_data_n = {{(WIDTH-1){1'b0}}, alu_zero};
                        res_load   = 1'b1;
                    end
                    OP_MIN: begin
                        lt_n       = alu_y[0];
                        res_data_n = alu_y[0] ? a_q : b_q;
                        res_load   = 1'b1;
                    end
                    OP_MAX: begin
                        lt_n       = alu_y[0];
                        res_data_n = alu_y[0] ? b_q : a_q;
                        res_load   = 1'b1;
                    end
                    OP_ABSDIFF: begin
                        // Order the subtraction so the larger operand is the minuend.
                        lt_n    = alu_y[0];
                        alu_a_n = alu_y[0] ? b_q : a_q;
                        alu_b_n = alu_y[0] ? a_q : b_q;
                        alu_f_n = F_SUB;
                        state_n = EXEC2;
                    end
                    default: begin
                        res_data_n = alu_y;
                        res_load   = 1'b1;
                    end
                endcase
            end

            EXEC2: begin
                res_data_n = alu_y;
                res_load   = 1'b1;
                state_n    = DONE;
            end

            DONE: begin
                if (res_ready) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase

        res_zero_n = res_load ? (res_data_n == '0) : res_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            lt_q     <= 1'b0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_f    <= F_AND;
            res_data <= '0;
            res_zero <= 1'b0;
            res_err  <= 1'b0;
        end else begin
            state    <= state_n;
            op_q     <= op_n;
            a_q      <= a_n;
            b_q      <= b_n;
            lt_q     <= lt_n;
            alu_a    <= alu_a_n;
            alu_b    <= alu_b_n;
            alu_f    <= alu_f_n;
            res_data <= res_data_n;
            res_zero <= res_zero_n;
            res_err  <= res_err_n;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural model of the external ALU.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_f;
    logic [31:0] alu_y;
    logic        alu_zero;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_zero;
    logic        res_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] data;
        logic        zero;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[17];

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_f     (alu_f),
        .alu_y     (alu_y),
        .alu_zero  (alu_zero),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_zero  (res_zero),
        .res_err   (res_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External ALU behaviour the sequencer is paired with.
    always_comb begin
        case (alu_f)
            3'b000:  alu_y = alu_a & alu_b;
            3'b001:  alu_y = alu_a | alu_b;
            3'b010:  alu_y = alu_a + alu_b;
            3'b100:  alu_y = alu_a & ~alu_b;
            3'b101:  alu_y = alu_a | ~alu_b;
            3'b110:  alu_y = alu_a - alu_b;
            3'b111:  alu_y = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            default: alu_y = 32'h0;
        endcase
        alu_zero = (alu_y == 32'h0);
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Presents one command at a negedge; returns #1 after the acceptance edge.
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        checkOutput("cmd_ready_before_issue", {31'b0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a     = 32'hDEAD_BEEF;
        cmd_b     = 32'hCAFE_F00D;
    endtask

    task automatic runVector(input vec_t v);
        int cycles;
        applyStimulus(v.op, v.a, v.b);
        cycles = 0;
        while (!res_valid && cycles < 8) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        if (!res_valid) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_timeout: res_valid never rose within %0d cycles", v.name, cycles);
        end else begin
            if (v.lat >= 0)
                checkOutput({v.name, "_latency"}, cycles, v.lat);
            checkOutput({v.name, "_data"}, res_data, v.data);
            checkOutput({v.name, "_zero"}, {31'b0, res_zero}, {31'b0, v.zero});
            checkOutput({v.name, "_err"}, {31'b0, res_err}, {31'b0, v.err});
            checkOutput({v.name, "_alu_f_idle"}, {29'b0, alu_f}, 32'd0);
        end
        @(posedge clk);
        #1;
        checkOutput({v.name, "_valid_drop"}, {31'b0, res_valid}, 32'd0);
    endtask

    initial begin
        vecs[0]  = '{"add",        4'd2,  32'h0000_0005, 32'h0000_0007, 32'h0000_000C, 1'b0, 1'b0, 1};
        vecs[1]  = '{"sub_zero",   4'd3,  32'h1234_ABCD, 32'h1234_ABCD, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[2]  = '{"eq_true",    4'd7,  32'h1234_ABCD, 32'h1234_ABCD, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[3]  = '{"eq_false",   4'd7,  32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[4]  = '{"and",        4'd0,  32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1'b0, 1};
        vecs[5]  = '{"or",         4'd1,  32'h0000_0F0F, 32'h0000_F000, 32'h0000_FF0F, 1'b0, 1'b0, 1};
        vecs[6]  = '{"slt_true",   4'd4,  32'hFFFF_FFFE, 32'h0000_0005, 32'h0000_0001, 1'b0, 1'b0, 1};
        vecs[7]  = '{"slt_false",  4'd4,  32'h0000_0005, 32'hFFFF_FFFE, 32'h0000_0000, 1'b1, 1'b0, 1};
        vecs[8]  = '{"andn",       4'd5,  32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0, 1'b0, 1};
        vecs[9]  = '{"orn",        4'd6,  32'h0000_0000, 32'hFFFF_FFF0, 32'h0000_000F, 1'b0, 1'b0, 1};
        vecs[10] = '{"sub_wrap",   4'd3,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 1};
        vecs[11] = '{"min_signed", 4'd8,  32'hFFFF_FFFE, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0, 1'b0, 1};
        vecs[12] = '{"max_signed", 4'd9,  32'hFFFF_FFFE, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 1};
        vecs[13] = '{"absdiff_lo", 4'd10, 32'h0000_0003, 32'h0000_000A, 32'h0000_0007, 1'b0, 1'b0, 2};
        vecs[14] = '{"absdiff_hi", 4'd10, 32'h0000_000A, 32'h0000_0003, 32'h0000_0007, 1'b0, 1'b0, 2};
        vecs[15] = '{"absdiff_eq", 4'd10, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1, 1'b0, 2};
        vecs[16] = '{"illegal11",  4'd11, 32'h0000_0001, 32'h0000_0001, 32'h0000_0000, 1'b1, 1'b1, -1};

        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_op    = 4'd0;
        cmd_a     = 32'h0;
        cmd_b     = 32'h0;
        res_ready = 1'b1;
        #12;
        checkOutput("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("rst_res_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("rst_res_data",  res_data, 32'd0);
        checkOutput("rst_res_zero",  {31'b0, res_zero}, 32'd0);
        checkOutput("rst_res_err",   {31'b0, res_err}, 32'd0);
        checkOutput("rst_alu_a",     alu_a, 32'd0);
        checkOutput("rst_alu_f",     {29'b0, alu_f}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++)
            runVector(vecs[i]);

        // ADD: ALU ports during EXEC1.
        applyStimulus(4'd2, 32'h5, 32'h7);
        checkOutput("add_exec1_f", {29'b0, alu_f}, 32'd2);
        checkOutput("add_exec1_a", alu_a, 32'h5);
        checkOutput("add_exec1_valid", {31'b0, res_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("add_done_data", res_data, 32'hC);
        @(posedge clk);
        #1;

        // ABSDIFF: compare pass then ordered subtract pass.
        applyStimulus(4'd10, 32'd3, 32'd10);
        checkOutput("abs_exec1_f", {29'b0, alu_f}, 32'd7);
        checkOutput("abs_exec1_a", alu_a, 32'd3);
        checkOutput("abs_exec1_b", alu_b, 32'd10);
        @(posedge clk);
        #1;
        checkOutput("abs_exec2_f", {29'b0, alu_f}, 32'd6);
        checkOutput("abs_exec2_a", alu_a, 32'd10);
        checkOutput("abs_exec2_b", alu_b, 32'd3);
        checkOutput("abs_exec2_valid", {31'b0, res_valid}, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("abs_done_valid", {31'b0, res_valid}, 32'd1);
        checkOutput("abs_done_data", res_data, 32'd7);
        checkOutput("abs_done_alu_a_hold", alu_a, 32'd10);
        @(posedge clk);
        #1;

        // Backpressure on an illegal op, with a competing command during DONE.
        res_ready = 1'b0;
        applyStimulus(4'd15, 32'h55, 32'h66);
        checkOutput("bp_valid_first", {31'b0, res_valid}, 32'd1);
        cmd_valid = 1'b1;
        cmd_op    = 4'd2;
        cmd_a     = 32'h1;
        cmd_b     = 32'h1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            checkOutput("bp_valid_hold", {31'b0, res_valid}, 32'd1);
            checkOutput("bp_data_hold",  res_data, 32'd0);
            checkOutput("bp_err_hold",   {31'b0, res_err}, 32'd1);
            checkOutput("bp_cmd_ready",  {31'b0, cmd_ready}, 32'd0);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("bp_release_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("bp_release_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk);
        #1;
        checkOutput("bp_no_accept", {31'b0, cmd_ready}, 32'd1);

        // Reset asserted while ABSDIFF is in its second pass.
        applyStimulus(4'd10, 32'd3, 32'd10);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'b0, res_valid}, 32'd0);
        checkOutput("midrst_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("midrst_alu_f", {29'b0, alu_f}, 32'd0);
        checkOutput("midrst_alu_a", alu_a, 32'd0);
        checkOutput("midrst_data",  res_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkOutput("midrst_no_result", {31'b0, res_valid}, 32'd0);
        end
        runVector(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
